// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory SRAM port between the core and a debug/DMA master.
// Optional perf counters are compiled in when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    input  logic [DATA_W-1:0] ReadDataMem,
`ifdef DMEM_ARB_PERF_EN
    input  logic              perf_clr,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_dbg_cnt,
`endif
    output logic              CEN,
    output logic              WEN,
    output logic              OEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] Data2Mem
);

    // A zero-width counter is illegal, so strict priority keeps one bit.
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     starve_q, starve_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              cpu_req;
    logic              gnt_dbg;
    logic              gnt_cpu;

    assign cpu_req = cpu_re | cpu_we;
    assign gnt_dbg = rst_n & dbg_req & (state_q != ACK)
                   & (~cpu_req | (starve_q >= WAIT_MAX));
    assign gnt_cpu = rst_n & cpu_req & ~gnt_dbg;

    assign cpu_rdata = ReadDataMem;
    assign cpu_stall = cpu_req & gnt_dbg;
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_ack   = (state_q == ACK);

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        dbg_rdata_d = dbg_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_dbg)      state_d = ACK;
                else if (dbg_req) state_d = WAIT;
            end
            WAIT: begin
                if (gnt_dbg)       state_d = ACK;
                else if (!dbg_req) state_d = IDLE;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (gnt_dbg || !dbg_req) begin
            starve_d = '0;
        end else if (state_q != ACK && starve_q < WAIT_MAX) begin
            starve_d = starve_q + 1'b1;
        end
        if (gnt_dbg && !dbg_we) begin
            dbg_rdata_d = ReadDataMem;
        end
    end

    // A store wins when the core raises both strobes.
    always_comb begin
        CEN      = 1'b1;
        WEN      = 1'b1;
        OEN      = 1'b1;
        A        = '0;
        Data2Mem = '0;
        unique case (1'b1)
            gnt_dbg: begin
                CEN      = 1'b0;
                WEN      = ~dbg_we;
                OEN      = dbg_we;
                A        = dbg_addr;
                Data2Mem = dbg_wdata;
            end
            gnt_cpu: begin
                CEN      = 1'b0;
                WEN      = ~cpu_we;
                OEN      = cpu_we;
                A        = cpu_addr;
                Data2Mem = cpu_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] pstall_q, pstall_d;
    logic [15:0] pdbg_q, pdbg_d;

    always_comb begin
        pstall_d = pstall_q;
        pdbg_d   = pdbg_q;
        if (cpu_stall && pstall_q != 16'hFFFF) pstall_d = pstall_q + 16'd1;
        if (gnt_dbg && pdbg_q != 16'hFFFF)     pdbg_d   = pdbg_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || perf_clr) begin
            pstall_q <= '0;
            pdbg_q   <= '0;
        end else begin
            pstall_q <= pstall_d;
            pdbg_q   <= pdbg_d;
        end
    end

    assign perf_stall_cnt = pstall_q;
    assign perf_dbg_cnt   = pdbg_q;
`endif

endmodule
